// File: rtl/iq_stream_source.sv
`default_nettype none
// ============================================================================
// Module   : iq_stream_source
// Purpose  : Buffers host-written (I, Q) sample pairs in a small FIFO and, on
//            start, replays a run of num_data_pts samples as single-cycle
//            data_in strobes spaced by a programmable interval.
// Ports    : clk100, reset (async, active-high)
//            wr_en, wr_i, wr_q      - FIFO push side
//            full, overflow         - FIFO status (overflow is sticky)
//            start, num_data_pts,
//            interval               - run control, latched on accepted start
//            data_in, i_val, q_val  - sample strobe and payload
//            busy, done, underrun   - run status
// Revision : 1.0 - initial release
// ============================================================================
module iq_stream_source #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                clk100,
  input  logic                reset,
  input  logic                wr_en,
  input  logic signed [W-1:0] wr_i,
  input  logic signed [W-1:0] wr_q,
  output logic                full,
  output logic                overflow,
  input  logic                start,
  input  logic [15:0]         num_data_pts,
  input  logic [7:0]          interval,
  output logic                data_in,
  output logic signed [W-1:0] i_val,
  output logic signed [W-1:0] q_val,
  output logic                busy,
  output logic                done,
  output logic                underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EMIT, GAP, FIN} state_t;

  state_t          state;
  logic [15:0]     remaining;
  logic [7:0]      ivl;
  logic [7:0]      gap;

  logic [W-1:0]    mem_i [DEPTH];
  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_next;

  logic            pop;
  logic            push;

  // The FSM consumes one entry whenever it sits in EMIT with data available.
  // A push while full is still accepted when that same cycle pops a slot.
  assign pop  = (state == EMIT) && (count != '0);
  assign push = wr_en && ((count != CNT_FULL) || pop);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_ONE;
    else if (pop && !push)
      count_next = count - CNT_ONE;
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk100) begin
    if (push) begin
      mem_i[wr_ptr] <= wr_i;
      mem_q[wr_ptr] <= wr_q;
    end
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      if (wr_en && (count == CNT_FULL) && !pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      ivl       <= '0;
      gap       <= '0;
      data_in   <= 1'b0;
      i_val     <= '0;
      q_val     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      data_in <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            underrun <= 1'b0;
            if (num_data_pts == 16'd0) begin
              state <= FIN;
            end else begin
              remaining <= num_data_pts;
              // Intervals below 2 cannot be honoured by the EMIT/GAP loop.
              ivl       <= (interval < 8'd2) ? 8'd2 : interval;
              busy      <= 1'b1;
              state     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (count != '0) begin
            data_in   <= 1'b1;
            i_val     <= mem_i[rd_ptr];
            q_val     <= mem_q[rd_ptr];
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state <= FIN;
            end else begin
              // EMIT cycle plus (ivl-1) GAP cycles gives ivl-cycle spacing.
              gap   <= ivl - 8'd1;
              state <= GAP;
            end
          end else begin
            underrun <= 1'b1;
          end
        end
        GAP: begin
          if (gap == 8'd1)
            state <= EMIT;
          else
            gap <= gap - 8'd1;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/iq_stream_source.md
# iq_stream_source

Transmit-side feeder for the IQ classification path. It buffers host-written (I, Q) sample pairs in a small FIFO. On `start` it emits a run of `num_data_pts` samples as single-cycle `data_in` strobes with `i_val`/`q_val`, paced by a programmable interval. It drives the same `data_in`/`i_val`/`q_val` interface that `classify_master` consumes, replacing bench-only stimulus in hardware bring-up.

## Interface
- `DEPTH`, 16: FIFO depth in sample pairs; power of two, at least 2.
- `W`, 32: signed width of I and Q samples.
- `clk100`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  push (`wr_i`, `wr_q`) into the FIFO this cycle.
- `wr_i`, `wr_q`  in  W  signed sample pair to push.
- `full`  out  1  FIFO holds DEPTH entries.
- `overflow`  out  1  sticky; a push was attempted while full. Cleared by reset only.
- `start`  in  1  begin a run; ignored unless the FSM is in IDLE.
- `num_data_pts`  in  16  samples per run; latched on an accepted `start`.
- `interval`  in  8  cycles between successive strobes; latched on start. Values 0 and 1 are treated as 2.
- `data_in`  out  1  one-cycle strobe; `i_val`/`q_val` are valid in that cycle.
- `i_val`, `q_val`  out  W  signed; hold their last emitted value between strobes.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle pulse at the end of a run.
- `underrun`  out  1  sticky; a strobe was delayed because the FIFO was empty. Cleared on accepted start.

## Operation
- FIFO: DEPTH entries, registered read and write pointers, count of width log2(DEPTH)+1.
  - A push while full is dropped and sets `overflow`.
  - A push and a pop in the same cycle both take effect, including while full; count is unchanged.
- FSM states are IDLE, EMIT, GAP and FIN.
- IDLE:
  - Accepted `start` with `num_data_pts` = 0 goes to FIN with no strobes.
  - Otherwise it latches `num_data_pts` into `remaining`, latches the effective interval, clears `underrun`, and goes to EMIT.
- EMIT, FIFO non-empty:
  - Pop the head entry; drive `i_val`/`q_val` from it and assert `data_in` for exactly one cycle.
  - Decrement `remaining`. If it reaches 0, go to FIN; otherwise load the gap counter with interval−1 and go to GAP.
- EMIT, FIFO empty:
  - No strobe; set `underrun`; stay in EMIT.
  - Emit on the first cycle the FIFO is non-empty. Pacing restarts from that strobe.
- GAP: decrement the gap counter each cycle; at 1, go to EMIT. Consecutive strobes are therefore exactly `interval` cycles apart when data is available.
- FIN: assert `done` for one cycle, then go to IDLE.
- `start` asserted in any state other than IDLE is ignored. `num_data_pts`/`interval` changes mid-run have no effect.
- Entries not consumed by a run remain in the FIFO for the next run.

## Timing
- Reset values: `data_in`, `done`, `busy`, `full`, `overflow` and `underrun` are 0; `i_val` and `q_val` are 0; FIFO empty; FSM in IDLE.
- Reset asserted mid-run aborts immediately: no `done` pulse, and FIFO contents are discarded.
- Start at edge N with data present: first `data_in` high during cycle N+1; strobe k is high during cycle N+1+k·interval.
- A pushed entry is poppable on the cycle after `wr_en`. Push at edge M into an empty FIFO while in EMIT gives a strobe during cycle M+1.
- `done` is high during the cycle after the last strobe; `busy` falls in the same cycle that `done` rises.
- Run with `num_data_pts` = 0: `done` high during cycle N+1; `busy` never asserts.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Preload 10 pairs (−3,−3)…(6,6); `interval` = 6; `num_data_pts` = 10; start → 10 strobes 6 cycles apart carrying −3…6, `done` one cycle after the 10th, `underrun` = 0.
- Preload 2 pairs; `num_data_pts` = 4; push 2 more 20 cycles later → strobes 3 and 4 follow the pushes by one cycle each, `underrun` = 1, then `done`.
- Fill 16 entries, push a 17th → `full` = 1, `overflow` = 1, 17th value never emitted; a same-cycle push+pop while full keeps count at 16.
- `interval` = 0 and `interval` = 1 → strobes every 2 cycles; `num_data_pts` = 0 → `done` at N+1, no strobe.
- Pulse `start` during GAP → ignored, run length unchanged.
- Assert `reset` between strobes 3 and 4 → all outputs 0 immediately, no `done`, FIFO empty; the next run waits for new pushes.
